cpu_trace_emitter: RTL and testbench



---
 rtl/cpu_trace_emitter_pkg.sv | 69 ++++++
 rtl/cpu_trace_emitter_if.sv | 25 ++
 rtl/cpu_trace_emitter_nibble_to_ascii.sv | 12 +
 rtl/cpu_trace_emitter.sv | 185 ++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/cpu_trace_emitter_pkg.sv
// Shared types and constants for the CPU trace line serializer.
// Holds the emitter state enum, ASCII codes, digit counts and nibble helpers.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CARET,
    ST_TIME,
    ST_AT,
    ST_PC,
    ST_COLON,
    ST_SPACE,
    ST_TAG,
    ST_FIELD,
    ST_ARROW,
    ST_DATA,
    ST_HASH
  } state_t;

  localparam logic [7:0] ASCII_CARET   = 8'h5e;
  localparam logic [7:0] ASCII_AT      = 8'h40;
  localparam logic [7:0] ASCII_COLON   = 8'h3a;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_DOLLAR  = 8'h24;
  localparam logic [7:0] ASCII_STAR    = 8'h2a;
  localparam logic [7:0] ASCII_LT      = 8'h3c;
  localparam logic [7:0] ASCII_EQ      = 8'h3d;
  localparam logic [7:0] ASCII_HASH    = 8'h23;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  localparam int WORD_DIGITS = 8;
  localparam int TIME_DIGITS = 4;

  localparam logic [3:0] WORD_LAST_IDX = 4'(WORD_DIGITS - 1);
  localparam logic [3:0] TIME_LAST_IDX = 4'(TIME_DIGITS - 1);

  function automatic logic time_is_bcd(input logic [15:0] t);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < TIME_DIGITS; d++) begin
      if (t[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Index (0 = most significant) of the first digit to print; 0000 prints its last digit.
  function automatic logic [3:0] time_first_digit(input logic [15:0] t);
    logic [3:0] idx;
    idx = TIME_LAST_IDX;
    for (int d = TIME_DIGITS - 2; d >= 0; d--) begin
      if (t[4*(TIME_DIGITS-1-d) +: 4] != 4'h0) idx = 4'(d);
    end
    return idx;
  endfunction

  function automatic logic [3:0] time_nibble(input logic [15:0] t, input logic [3:0] idx);
    int sh;
    sh = 4 * (TIME_DIGITS - 1 - (int'(idx) & 3));
    return t[sh +: 4];
  endfunction

  function automatic logic [3:0] word_nibble(input logic [31:0] w, input logic [3:0] idx);
    int sh;
    sh = 4 * (WORD_DIGITS - 1 - (int'(idx) & 7));
    return w[sh +: 4];
  endfunction

endpackage

// File: rtl/cpu_trace_emitter_if.sv
// Request/character bundle between the write-back observer and the trace emitter.
interface cpu_trace_emitter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_type;
  logic [15:0] req_time;
  logic [31:0] req_pc;
  logic [4:0]  req_grf;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_err;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_last;

  modport master (
    output req_valid, req_type, req_time, req_pc, req_grf, req_addr, req_data,
    input  req_ready, req_err, char, char_valid, char_last
  );

  modport slave (
    input  req_valid, req_type, req_time, req_pc, req_grf, req_addr, req_data,
    output req_ready, req_err, char, char_valid, char_last
  );
endinterface

// File: rtl/cpu_trace_emitter_nibble_to_ascii.sv
// Combinational 4-bit value to lowercase hex / decimal ASCII character.
module nibble_to_ascii
  import cpu_trace_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_ZERO + {4'h0, nibble};
    else                ascii = ASCII_LOWER_A + {4'h0, nibble} - 8'd10;
  end
endmodule

// File: rtl/cpu_trace_emitter.sv
// Latches one write-back event and streams its ASCII trace line, one character per cycle.
// Outputs decode the registered state directly, so the '^' appears the cycle after accept.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input logic               clk,
  input logic               reset,
  cpu_trace_emitter_if.slave bus
);
  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic        type_reg;
  logic [15:0] time_reg;
  logic [3:0]  time_start_reg;
  logic [31:0] pc_reg;
  logic [4:0]  grf_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;

  logic        ready;
  logic        accept;
  logic        field_last;
  logic [1:0]  grf_tens;
  logic [4:0]  grf_ones;
  logic [3:0]  digit;
  logic [7:0]  digit_char;
  logic [7:0]  char_out;

  // '#' cycle also accepts, giving gap-free back-to-back lines.
  assign ready  = (state_reg == ST_IDLE) || (state_reg == ST_HASH);
  assign accept = bus.req_valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'h0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      type_reg       <= bus.req_type;
      time_reg       <= bus.req_time;
      time_start_reg <= time_first_digit(bus.req_time);
      pc_reg         <= bus.req_pc;
      grf_reg        <= bus.req_grf;
      addr_reg       <= bus.req_addr;
      data_reg       <= bus.req_data;
    end
  end

  // Register number in decimal: tens by threshold compare, ones by subtraction.
  always_comb begin
    grf_tens = 2'd0;
    grf_ones = grf_reg;
    if (grf_reg >= 5'd30) begin
      grf_tens = 2'd3;
      grf_ones = grf_reg - 5'd30;
    end else if (grf_reg >= 5'd20) begin
      grf_tens = 2'd2;
      grf_ones = grf_reg - 5'd20;
    end else if (grf_reg >= 5'd10) begin
      grf_tens = 2'd1;
      grf_ones = grf_reg - 5'd10;
    end
  end

  assign field_last = type_reg ? (cnt_reg == WORD_LAST_IDX) : (cnt_reg == 4'd1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      ST_CARET: begin
        state_next = ST_TIME;
        cnt_next   = time_start_reg;
      end
      ST_TIME: begin
        if (cnt_reg == TIME_LAST_IDX) state_next = ST_AT;
        else                          cnt_next   = cnt_reg + 4'd1;
      end
      ST_AT: begin
        state_next = ST_PC;
        cnt_next   = 4'h0;
      end
      ST_PC: begin
        if (cnt_reg == WORD_LAST_IDX) state_next = ST_COLON;
        else                          cnt_next   = cnt_reg + 4'd1;
      end
      ST_COLON: state_next = ST_SPACE;
      ST_SPACE: state_next = ST_TAG;
      ST_TAG: begin
        state_next = ST_FIELD;
        // Single-digit register numbers skip straight to the ones slot.
        cnt_next   = (type_reg || grf_tens != 2'd0) ? 4'h0 : 4'h1;
      end
      ST_FIELD: begin
        if (field_last) begin
          state_next = ST_ARROW;
          cnt_next   = 4'h0;
        end else begin
          cnt_next   = cnt_reg + 4'd1;
        end
      end
      ST_ARROW: begin
        if (cnt_reg == 4'd3) begin
          state_next = ST_DATA;
          cnt_next   = 4'h0;
        end else begin
          cnt_next   = cnt_reg + 4'd1;
        end
      end
      ST_DATA: begin
        if (cnt_reg == WORD_LAST_IDX) state_next = ST_HASH;
        else                          cnt_next   = cnt_reg + 4'd1;
      end
      default: begin
        // ST_IDLE and ST_HASH: both may take a new event.
        state_next = ST_IDLE;
        if (accept) begin
          if (time_is_bcd(bus.req_time)) state_next = ST_CARET;
          else                           err_next   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    digit = 4'h0;
    case (state_reg)
      ST_TIME:  digit = time_nibble(time_reg, cnt_reg);
      ST_PC:    digit = word_nibble(pc_reg, cnt_reg);
      ST_FIELD: begin
        if (type_reg)              digit = word_nibble(addr_reg, cnt_reg);
        else if (cnt_reg == 4'h0)  digit = {2'b00, grf_tens};
        else                       digit = 4'(grf_ones);
      end
      ST_DATA:  digit = word_nibble(data_reg, cnt_reg);
      default:  digit = 4'h0;
    endcase
  end

  nibble_to_ascii u_digit (
    .nibble (digit),
    .ascii  (digit_char)
  );

  always_comb begin
    char_out = 8'h00;
    case (state_reg)
      ST_CARET: char_out = ASCII_CARET;
      ST_TIME,
      ST_PC,
      ST_FIELD,
      ST_DATA:  char_out = digit_char;
      ST_AT:    char_out = ASCII_AT;
      ST_COLON: char_out = ASCII_COLON;
      ST_SPACE: char_out = ASCII_SPACE;
      ST_TAG:   char_out = type_reg ? ASCII_STAR : ASCII_DOLLAR;
      ST_ARROW: begin
        case (cnt_reg)
          4'd1:    char_out = ASCII_LT;
          4'd2:    char_out = ASCII_EQ;
          default: char_out = ASCII_SPACE;
        endcase
      end
      ST_HASH:  char_out = ASCII_HASH;
      default:  char_out = 8'h00;
    endcase
  end

  assign bus.req_ready  = ready;
  assign bus.req_err    = err_reg;
  assign bus.char       = char_out;
  assign bus.char_valid = (state_reg != ST_IDLE);
  assign bus.char_last  = (state_reg == ST_HASH);

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: captures each emitted line and compares it
// with hand-written expected text, plus handshake timing, rejection and reset cases.
module tb_cpu_trace_emitter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_trace_emitter_if bus();

  cpu_trace_emitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic typ, input logic [15:0] tm, input logic [31:0] pc,
                       input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.req_type  = typ;
    bus.req_time  = tm;
    bus.req_pc    = pc;
    bus.req_grf   = grf;
    bus.req_addr  = addr;
    bus.req_data  = data;
  endtask

  // Called at the falling edge of the first character cycle; returns at the '#' cycle.
  task automatic check_line(input string name, input logic [319:0] exp, input int exp_len);
    logic [319:0] text;
    string        s;
    int           len, gaps, bad_ready, bad_last;
    bit           done;
    text = '0; s = ""; len = 0; gaps = 0; bad_ready = 0; bad_last = 0; done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!bus.char_valid) gaps++;
      else begin
        text = {text[311:0], bus.char};
        s = {s, $sformatf("%c", bus.char)};
        len++;
      end
      if (bus.char_last && bus.char != 8'h23) bad_last++;
      if (!bus.char_last && bus.char == 8'h23) bad_last++;
      if (bus.req_ready !== bus.char_last) bad_ready++;
      if (bus.char_last) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    $display("line %s: %0d chars '%s'", name, len, s);
    check({name, "_finished"}, 320'(done), 320'(1));
    check({name, "_text"}, text, exp);
    check({name, "_length"}, 320'(len), 320'(exp_len));
    check({name, "_gaps"}, 320'(gaps), 320'(0));
    check({name, "_ready_timing"}, 320'(bad_ready), 320'(0));
    check({name, "_last_marker"}, 320'(bad_last), 320'(0));
  endtask

  // Called at a falling edge with the emitter idle; returns one cycle after the '#'.
  task automatic run_single(input string name, input logic typ, input logic [15:0] tm,
                            input logic [31:0] pc, input logic [4:0] grf, input logic [31:0] addr,
                            input logic [31:0] data, input logic [319:0] exp, input int exp_len);
    drive(typ, tm, pc, grf, addr, data);
    check({name, "_ready_before"}, 320'(bus.req_ready), 320'(1));
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_line(name, exp, exp_len);
    @(negedge clk);
    check({name, "_idle_after"}, 320'(bus.char_valid), 320'(0));
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_type  = 1'b0;
    bus.req_time  = 16'h0;
    bus.req_pc    = 32'h0;
    bus.req_grf   = 5'h0;
    bus.req_addr  = 32'h0;
    bus.req_data  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 320'(bus.req_ready), 320'(1));
    check("reset_char_valid", 320'(bus.char_valid), 320'(0));
    check("reset_char_last", 320'(bus.char_last), 320'(0));
    check("reset_req_err", 320'(bus.req_err), 320'(0));
    check("reset_char", 320'(bus.char), 320'(0));
    reset = 1'b0;
    @(negedge clk);

    run_single("reg_write", 1'b0, 16'h0012, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd,
               320'("^12@00003000: $5 <= 0000abcd#"), 29);
    run_single("mem_write", 1'b1, 16'h0007, 32'h0000_3004, 5'd0, 32'h0000_0010, 32'hdead_beef,
               320'("^7@00003004: *00000010 <= deadbeef#"), 35);
    run_single("time0_grf31", 1'b0, 16'h0000, 32'h0000_0040, 5'd31, 32'h0, 32'h0000_0001,
               320'("^0@00000040: $31 <= 00000001#"), 29);
    run_single("time9999_mem", 1'b1, 16'h9999, 32'hffff_ffff, 5'd0, 32'ha5a5_a5a5, 32'h0,
               320'("^9999@ffffffff: *a5a5a5a5 <= 00000000#"), 38);
    run_single("time0100_grf10", 1'b0, 16'h0100, 32'h1234_5678, 5'd10, 32'h0, 32'h89ab_cdef,
               320'("^100@12345678: $10 <= 89abcdef#"), 31);

    // Back-to-back: keep req_valid high so the second event is taken on the '#' cycle.
    drive(1'b0, 16'h0012, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 16'h0007, 32'h0000_3004, 5'd0, 32'h0000_0010, 32'hdead_beef);
    check_line("b2b_first", 320'("^12@00003000: $5 <= 0000abcd#"), 29);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_line("b2b_second", 320'("^7@00003004: *00000010 <= deadbeef#"), 35);
    @(negedge clk);
    check("b2b_idle_after", 320'(bus.char_valid), 320'(0));

    // Non-BCD time nibble is rejected.
    drive(1'b0, 16'h00a1, 32'h0000_3000, 5'd1, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("reject_err_pulse", 320'(bus.req_err), 320'(1));
    check("reject_char_valid", 320'(bus.char_valid), 320'(0));
    check("reject_ready", 320'(bus.req_ready), 320'(1));
    @(negedge clk);
    check("reject_err_cleared", 320'(bus.req_err), 320'(0));
    check("reject_still_idle", 320'(bus.char_valid), 320'(0));

    // Reset in the middle of a line, at its 10th character.
    drive(1'b0, 16'h0012, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check("midline_char10", 320'(bus.char), 320'(8'h30));
    check("midline_valid10", 320'(bus.char_valid), 320'(1));
    reset = 1'b1;
    @(negedge clk);
    check("midline_reset_valid", 320'(bus.char_valid), 320'(0));
    check("midline_reset_ready", 320'(bus.req_ready), 320'(1));
    check("midline_reset_char", 320'(bus.char), 320'(0));
    reset = 1'b0;
    @(negedge clk);
    run_single("after_reset", 1'b1, 16'h0007, 32'h0000_3004, 5'd0, 32'h0000_0010, 32'hdead_beef,
               320'("^7@00003004: *00000010 <= deadbeef#"), 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
